memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the EX/MEM register outputs (alu_result_m, write_data_m, pc_plus4_m, rd_m, result_src_m, mem_write_m, reg_write_m).
- Performs word loads and stores over a request/ready data-memory port, and drives stall_m to the hazard unit while an access is pending.
- Owns the MEM/WB pipeline register that feeds writeback.

Parameters:
- TIMEOUT, 16, maximum number of WAIT cycles before an access is aborted; 0 disables the timeout.
- CNT_W, 8, width of the wait counter; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- srst  in  1  synchronous reset, active-high.
- alu_result_m  in  32  effective address, or ALU result for non-memory instructions.
- write_data_m  in  32  store data.
- pc_plus4_m  in  32  PC+4 of the instruction.
- rd_m  in  5  destination register.
- result_src_m  in  2  result select: 00 = ALU, 01 = memory (load), 10 = PC+4.
- mem_write_m  in  1  store enable.
- reg_write_m  in  1  register-file write enable.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  32  word address, driven from alu_result_m.
- dmem_wdata  out  32  write data, driven from write_data_m.
- dmem_rdata  in  32  read data; valid in the cycle dmem_ready = 1.
- dmem_ready  in  1  access complete this cycle.
- stall_m  out  1  to hazard unit; freezes PC, IF/ID, ID/EX and EX/MEM.
- misalign_err  out  1  one-cycle pulse: misaligned access dropped.
- bus_err  out  1  one-cycle pulse: access aborted by timeout.
- alu_result_w  out  32  MEM/WB register.
- read_data_w  out  32  MEM/WB register.
- pc_plus4_w  out  32  MEM/WB register.
- rd_w  out  5  MEM/WB register.
- result_src_w  out  2  MEM/WB register.
- reg_write_w  out  1  MEM/WB register.

Behaviour:
- Access detection:
  - load = (result_src_m == 01); store = mem_write_m.
  - access = load | store.
  - aligned = (alu_result_m[1:0] == 00).
- FSM states: IDLE, WAIT.
  - Counter wcnt is CNT_W bits and resets to 0.
- IDLE:
  - If access & aligned: dmem_req = 1 combinationally, with dmem_we = store.
    - If dmem_ready = 1 in the same cycle: zero-wait access; stall_m = 0; the MEM/WB register captures the result; remain in IDLE.
    - Otherwise: stall_m = 1; go to WAIT; wcnt <= 1.
  - If access & !aligned:
    - dmem_req = 0.
    - misalign_err pulses for one cycle.
    - MEM/WB loads a bubble (reg_write_w = 0, all other fields 0).
    - No stall.
  - Non-access instruction: passes straight to MEM/WB; no stall.
- WAIT:
  - dmem_req = 1 held; address, data and dmem_we stay stable because upstream is frozen.
  - stall_m = !dmem_ready.
  - On dmem_ready = 1: MEM/WB captures the result; go to IDLE; wcnt <= 0.
  - Else if TIMEOUT != 0 and wcnt == TIMEOUT:
    - dmem_req remains 1 this cycle.
    - Abort: bus_err pulses, stall_m = 0, MEM/WB loads a bubble.
    - Go to IDLE.
  - Otherwise: wcnt <= wcnt + 1.
- MEM/WB register:
  - Every cycle it loads either the current instruction or a bubble. It never holds.
  - A bubble is loaded whenever stall_m = 1, on a misaligned access, and on a timeout abort.
  - read_data_w <= dmem_rdata on load completion, otherwise 0.
  - A store writes reg_write_w as delivered by reg_write_m (normally 0).
- Reset:
  - While srst = 1: dmem_req = 0, stall_m = 0, misalign_err = 0, bus_err = 0, all combinationally forced.
  - FSM goes to IDLE, wcnt to 0, all MEM/WB outputs to 0.
  - Reset during WAIT abandons the access silently; no bus_err.
- Back-to-back accesses: after completion the FSM is back in IDLE in the next cycle, and the next EX/MEM instruction can issue its request immediately.
- dmem_ready arriving while dmem_req = 0 is ignored.

Test Plan:
- Zero-wait load: addr = 0x100, dmem_ready = 1 in the same cycle, rdata = 0xDEADBEEF, rd_m = 5 -> stall_m never 1; next cycle read_data_w = 0xDEADBEEF, rd_w = 5, reg_write_w = 1.
- Store with 3 wait cycles: addr = 0x204, wdata = 0x12345678, ready on the 4th request cycle -> dmem_req high for 4 cycles with stable address and data; stall_m = 1 for 3 cycles; reg_write_w = 0 throughout.
- Timeout, TIMEOUT = 4: load, ready never asserted -> bus_err pulses in the 5th request cycle; stall_m drops that cycle; reg_write_w = 0; FSM returns to IDLE.
- Misaligned load: addr = 0x102 -> dmem_req = 0, misalign_err = 1 for one cycle, reg_write_w = 0, no stall.
- Reset in WAIT: srst asserted in the 2nd wait cycle -> dmem_req = 0 in the same cycle; all outputs 0 next cycle; no bus_err.
- Back-to-back zero-wait loads followed by an ALU op (result_src = 00, alu_result = 7) -> three consecutive MEM/WB updates with no bubble; alu_result_w = 7 on the third.

Source files
------------

// File: rtl/memory_stage.sv
// Memory stage: word loads/stores over a req/ready data port, stall generation
// for the hazard unit, and the MEM/WB pipeline register.
module memory_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        srst,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] write_data_m,
    input  logic [31:0] pc_plus4_m,
    input  logic [4:0]  rd_m,
    input  logic [1:0]  result_src_m,
    input  logic        mem_write_m,
    input  logic        reg_write_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall_m,
    output logic        misalign_err,
    output logic        bus_err,
    output logic [31:0] alu_result_w,
    output logic [31:0] read_data_w,
    output logic [31:0] pc_plus4_w,
    output logic [4:0]  rd_w,
    output logic [1:0]  result_src_w,
    output logic        reg_write_w
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] wcnt;

    logic load;
    logic store;
    logic access;
    logic aligned;
    logic req_c;
    logic done;
    logic tmo_hit;
    logic bubble;

    always_comb begin
        load    = (result_src_m == 2'b01);
        store   = mem_write_m;
        access  = load | store;
        aligned = (alu_result_m[1:0] == 2'b00);
        req_c   = 1'b0;
        unique case (1'b1)
            (state == S_IDLE): req_c = access & aligned;
            (state == S_WAIT): req_c = 1'b1;
            default:           req_c = 1'b0;
        endcase
        tmo_hit = (TIMEOUT != 0) && (state == S_WAIT)
                  && !dmem_ready && (wcnt == TMO);
        // Reset overrides every handshake/status output immediately
        dmem_req     = req_c & ~srst;
        done         = dmem_req & dmem_ready;
        stall_m      = dmem_req & ~dmem_ready & ~tmo_hit;
        misalign_err = ~srst & (state == S_IDLE) & access & ~aligned;
        bus_err      = ~srst & tmo_hit;
        bubble       = stall_m | misalign_err | bus_err;
    end

    assign dmem_we    = store;
    assign dmem_addr  = alu_result_m;
    assign dmem_wdata = write_data_m;

    always_ff @(posedge clk) begin
        if (srst) begin
            state        <= S_IDLE;
            wcnt         <= '0;
            alu_result_w <= '0;
            read_data_w  <= '0;
            pc_plus4_w   <= '0;
            rd_w         <= '0;
            result_src_w <= '0;
            reg_write_w  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (dmem_req && !dmem_ready) begin
                        state <= S_WAIT;
                        wcnt  <= CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_ready || tmo_hit) begin
                        state <= S_IDLE;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    wcnt  <= '0;
                end
            endcase

            if (bubble) begin
                alu_result_w <= '0;
                read_data_w  <= '0;
                pc_plus4_w   <= '0;
                rd_w         <= '0;
                result_src_w <= '0;
                reg_write_w  <= 1'b0;
            end else begin
                alu_result_w <= alu_result_m;
                read_data_w  <= (load && done) ? dmem_rdata : '0;
                pc_plus4_w   <= pc_plus4_m;
                rd_w         <= rd_m;
                result_src_w <= result_src_m;
                reg_write_w  <= reg_write_m;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: vector table for single-cycle cases plus
// hand-written wait, timeout and reset sequences; MEM/WB via scoreboard.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        srst;
    logic [31:0] alu_result_m;
    logic [31:0] write_data_m;
    logic [31:0] pc_plus4_m;
    logic [4:0]  rd_m;
    logic [1:0]  result_src_m;
    logic        mem_write_m;
    logic        reg_write_m;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        stall_m;
    logic        misalign_err;
    logic        bus_err;
    logic [31:0] alu_result_w;
    logic [31:0] read_data_w;
    logic [31:0] pc_plus4_w;
    logic [4:0]  rd_w;
    logic [1:0]  result_src_w;
    logic        reg_write_w;

    always #5 clk = ~clk;

    memory_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .srst(srst),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .pc_plus4_m(pc_plus4_m), .rd_m(rd_m),
        .result_src_m(result_src_m), .mem_write_m(mem_write_m),
        .reg_write_m(reg_write_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .stall_m(stall_m), .misalign_err(misalign_err), .bus_err(bus_err),
        .alu_result_w(alu_result_w), .read_data_w(read_data_w),
        .pc_plus4_w(pc_plus4_w), .rd_w(rd_w),
        .result_src_w(result_src_w), .reg_write_w(reg_write_w)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic        rw;
    } wb_t;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic        mw;
        logic        rw;
        logic        rdy;
        logic        e_req;
        logic        e_stall;
        logic        e_merr;
        wb_t         e_wb;
    } vec_t;

    int  n_chk  = 0;
    int  n_fail = 0;
    wb_t exp_q[$];
    wb_t bub = '{32'h0, 32'h0, 32'h0, 5'h0, 2'h0, 1'b0};
    vec_t vecs[7];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [31:0] rdat,
                         input logic [4:0] r, input logic [1:0] s,
                         input logic mw, input logic rw, input logic rdy);
        alu_result_m = a;
        write_data_m = wd;
        pc_plus4_m   = pc;
        dmem_rdata   = rdat;
        rd_m         = r;
        result_src_m = s;
        mem_write_m  = mw;
        reg_write_m  = rw;
        dmem_ready   = rdy;
    endtask

    // Checks combinational outputs mid-cycle, then the MEM/WB update
    task automatic cyc(input string tag, input logic e_req,
                       input logic e_stall, input logic e_merr,
                       input logic e_berr, input wb_t e,
                       input logic do_bus, input logic [31:0] e_addr,
                       input logic [31:0] e_wdata, input logic e_we);
        wb_t g;
        #3;
        check({tag, ".req"}, 32'(dmem_req), 32'(e_req));
        check({tag, ".stall"}, 32'(stall_m), 32'(e_stall));
        check({tag, ".merr"}, 32'(misalign_err), 32'(e_merr));
        check({tag, ".berr"}, 32'(bus_err), 32'(e_berr));
        if (do_bus) begin
            check({tag, ".addr"}, dmem_addr, e_addr);
            check({tag, ".wdata"}, dmem_wdata, e_wdata);
            check({tag, ".we"}, 32'(dmem_we), 32'(e_we));
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        check({tag, ".alu_w"}, alu_result_w, g.alu);
        check({tag, ".rdata_w"}, read_data_w, g.rdata);
        check({tag, ".pc_w"}, pc_plus4_w, g.pc);
        check({tag, ".rd_w"}, 32'(rd_w), 32'(g.rd));
        check({tag, ".src_w"}, 32'(result_src_w), 32'(g.src));
        check({tag, ".rw_w"}, 32'(reg_write_w), 32'(g.rw));
    endtask

    initial begin
        vecs[0] = '{32'h100, 32'h0, 32'h1004, 32'hDEADBEEF, 5'd5, 2'b01,
                    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                    '{32'h100, 32'hDEADBEEF, 32'h1004, 5'd5, 2'b01, 1'b1}};
        vecs[1] = '{32'h104, 32'h0, 32'h1008, 32'hCAFEF00D, 5'd6, 2'b01,
                    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                    '{32'h104, 32'hCAFEF00D, 32'h1008, 5'd6, 2'b01, 1'b1}};
        vecs[2] = '{32'h7, 32'h0, 32'h100C, 32'h0, 5'd7, 2'b00,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    '{32'h7, 32'h0, 32'h100C, 5'd7, 2'b00, 1'b1}};
        vecs[3] = '{32'h102, 32'h0, 32'h1010, 32'h55, 5'd8, 2'b01,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, bub};
        vecs[4] = '{32'h203, 32'h99, 32'h1014, 32'h0, 5'd0, 2'b00,
                    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, bub};
        vecs[5] = '{32'h40, 32'h0, 32'h2000, 32'hBAD, 5'd1, 2'b10,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                    '{32'h40, 32'h0, 32'h2000, 5'd1, 2'b10, 1'b1}};
        vecs[6] = '{32'h208, 32'hA5A5, 32'h2004, 32'h0, 5'd3, 2'b00,
                    1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                    '{32'h208, 32'h0, 32'h2004, 5'd3, 2'b00, 1'b0}};

        // Reset with a ready load presented: everything must stay quiet
        srst = 1'b1;
        drive(32'h100, 32'h1, 32'h8, 32'hFFFF, 5'd4, 2'b01, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++)
            cyc("reset", 0, 0, 0, 0, bub, 0, 0, 0, 0);
        srst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].alu, vecs[i].wdata, vecs[i].pc, vecs[i].rdata,
                  vecs[i].rd, vecs[i].src, vecs[i].mw, vecs[i].rw,
                  vecs[i].rdy);
            cyc($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_stall,
                vecs[i].e_merr, 0, vecs[i].e_wb, 0, 0, 0, 0);
        end

        // Store with three wait cycles
        drive(32'h204, 32'h12345678, 32'h3000, 32'h0, 5'd0, 2'b00,
              1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("st_wait", 1, 1, 0, 0, bub, 1, 32'h204, 32'h12345678, 1);
        dmem_ready = 1'b1;
        cyc("st_done", 1, 0, 0, 0,
            '{32'h204, 32'h0, 32'h3000, 5'd0, 2'b00, 1'b0},
            1, 32'h204, 32'h12345678, 1);

        // Load that never completes: abort in the fifth request cycle
        drive(32'h300, 32'h0, 32'h4000, 32'h0, 5'd9, 2'b01, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc("tmo_wait", 1, 1, 0, 0, bub, 1, 32'h300, 32'h0, 0);
        cyc("tmo_abort", 1, 0, 0, 1, bub, 0, 0, 0, 0);
        drive(32'h11, 32'h0, 32'h4004, 32'h0, 5'd10, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc("tmo_alu", 0, 0, 0, 0,
            '{32'h11, 32'h0, 32'h4004, 5'd10, 2'b00, 1'b1}, 0, 0, 0, 0);
        drive(32'h304, 32'h0, 32'h4008, 32'h77, 5'd11, 2'b01, 1'b0, 1'b1, 1'b1);
        cyc("tmo_next", 1, 0, 0, 0,
            '{32'h304, 32'h77, 32'h4008, 5'd11, 2'b01, 1'b1}, 0, 0, 0, 0);

        // Reset asserted in the second wait cycle
        drive(32'h400, 32'h0, 32'h5000, 32'h0, 5'd12, 2'b01, 1'b0, 1'b1, 1'b0);
        cyc("rw_req", 1, 1, 0, 0, bub, 0, 0, 0, 0);
        cyc("rw_wait1", 1, 1, 0, 0, bub, 0, 0, 0, 0);
        srst = 1'b1;
        cyc("rw_srst", 0, 0, 0, 0, bub, 0, 0, 0, 0);
        srst = 1'b0;
        drive(32'h22, 32'h0, 32'h5004, 32'h0, 5'd13, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc("rw_after", 0, 0, 0, 0,
            '{32'h22, 32'h0, 32'h5004, 5'd13, 2'b00, 1'b1}, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
